// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage.
// Contents:
//   - Result-select encodings driven by ResultSrcW.
//   - Default datapath and register-address widths.
package wb_pkg;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;
    localparam logic [1:0] RES_RSV = 2'b11;

    localparam int XLEN_DEF   = 32;
    localparam int REG_AW_DEF = 5;

endpackage

// File: rtl/wb_late_fifo.sv
// Late-result buffer for divider writebacks.
// It is a DEPTH-entry synchronous FIFO. Each entry holds {rd, data, killed}.
// Ports:
//   clk_i, rst_ni      clock, asynchronous active-low reset
//   push_i             write an entry (ignored when full)
//   push_rd_i          destination register of the entry
//   push_data_i        data of the entry
//   push_killed_i      store the entry already killed
//   pop_i              drop the head entry (ignored when empty)
//   kill_en_i          mark every stored entry whose rd matches kill_rd_i as killed
//   kill_rd_i          register compared against every stored entry
//   head_rd_o          head entry destination register
//   head_data_o        head entry data
//   head_killed_o      head entry killed flag
//   full_o, empty_o, count_o   occupancy
module wb_late_fifo
    import wb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEF,
    parameter int REG_AW = REG_AW_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  logic [REG_AW-1:0]          push_rd_i,
    input  logic [XLEN-1:0]            push_data_i,
    input  logic                       push_killed_i,
    input  logic                       pop_i,
    input  logic                       kill_en_i,
    input  logic [REG_AW-1:0]          kill_rd_i,
    output logic [REG_AW-1:0]          head_rd_o,
    output logic [XLEN-1:0]            head_data_o,
    output logic                       head_killed_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [REG_AW-1:0] rd_mem   [DEPTH];
    logic [XLEN-1:0]   data_mem [DEPTH];
    logic [DEPTH-1:0]  kill_q;

    logic [PW-1:0] rptr_q, wptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    assign head_rd_o     = rd_mem[rptr_q];
    assign head_data_o   = data_mem[rptr_q];
    assign head_killed_o = kill_q[rptr_q];

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Storage needs no reset: occupancy alone decides which slots are live.
    // The push is written after the kill loop so that it overrides the kill.
    // The killed state of a new entry comes from push_killed_i alone.
    always_ff @(posedge clk_i) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (kill_en_i && (rd_mem[i] == kill_rd_i)) begin
                kill_q[i] <= 1'b1;
            end
        end
        if (do_push) begin
            rd_mem[wptr_q]   <= push_rd_i;
            data_mem[wptr_q] <= push_data_i;
            kill_q[wptr_q]   <= push_killed_i;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rptr_q  <= '0;
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/wb_arbiter_stage.sv
// Writeback stage of the RV32IM pipeline.
// It selects the in-order W-stage result and drives the register-file write port.
// Late divider results go through a small buffer and use the write port only
// when the pipeline does not need it.
// It also counts retired instructions and keeps a sticky flag for the reserved
// result-select encoding.
// Ports:
//   clk, rst (async, active-low)
//   ValidW, RegWriteW, RdW, ResultSrcW                 W-stage control
//   ALU_ResultW, ReadDataW, PCPlus4W                   W-stage candidate results
//   div_valid, div_rd, div_data                        divider offer
//   div_ready                                          divider handshake back
//   ResultW                                            selected result (forwarding)
//   rf_we, rf_addr, rf_wdata                           register-file write port
//   wb_pending, instret, err_src                       status
// Handshake: a divider result transfers on a rising edge where div_valid and
// div_ready are both high. div_ready never depends on div_valid.
module wb_arbiter_stage
    import wb_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ValidW,
    input  logic              RegWriteW,
    input  logic [REG_AW-1:0] RdW,
    input  logic [1:0]        ResultSrcW,
    input  logic [XLEN-1:0]   ALU_ResultW,
    input  logic [XLEN-1:0]   ReadDataW,
    input  logic [XLEN-1:0]   PCPlus4W,
    input  logic              div_valid,
    input  logic [REG_AW-1:0] div_rd,
    input  logic [XLEN-1:0]   div_data,
    output logic              div_ready,
    output logic [XLEN-1:0]   ResultW,
    output logic              rf_we,
    output logic [REG_AW-1:0] rf_addr,
    output logic [XLEN-1:0]   rf_wdata,
    output logic              wb_pending,
    output logic [CNT_W-1:0]  instret,
    output logic              err_src
);

    logic              pipe_wr;
    logic              push, pop, push_killed;
    logic [REG_AW-1:0] head_rd;
    logic [XLEN-1:0]   head_data;
    logic              head_killed, full, empty;
    logic [$clog2(DEPTH):0] count;

    logic              alive_q;
    logic [CNT_W-1:0]  instret_q;
    logic              err_q;

    always_comb begin
        ResultW = '0;
        case (ResultSrcW)
            RES_ALU: ResultW = ALU_ResultW;
            RES_MEM: ResultW = ReadDataW;
            RES_PC4: ResultW = PCPlus4W;
            default: ResultW = '0;
        endcase
    end

    assign pipe_wr = ValidW & RegWriteW & (RdW != '0);

    // The pipeline always has priority. A killed head is dropped even while
    // the pipeline writes, so stale entries do not block the buffer.
    assign pop = ~empty & (head_killed | ~pipe_wr);

    // rf_we is forced low through rst itself, so it drops as soon as reset is
    // asserted and does not wait for a clock edge.
    assign rf_we    = rst & (pipe_wr | (~empty & ~head_killed));
    assign rf_addr  = pipe_wr ? RdW : head_rd;
    assign rf_wdata = pipe_wr ? ResultW : head_data;

    // alive_q holds div_ready low until the first edge after reset is released.
    assign div_ready   = alive_q & ~full;
    assign push        = div_valid & div_ready;
    // A divider result aimed at the register the pipeline writes in the same
    // cycle is the older value, so it is stored already killed.
    assign push_killed = (div_rd == '0) | (pipe_wr & (div_rd == RdW));

    assign wb_pending = (count != '0);
    assign instret    = instret_q;
    assign err_src    = err_q;

    wb_late_fifo #(
        .XLEN   (XLEN),
        .REG_AW (REG_AW),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i         (clk),
        .rst_ni        (rst),
        .push_i        (push),
        .push_rd_i     (div_rd),
        .push_data_i   (div_data),
        .push_killed_i (push_killed),
        .pop_i         (pop),
        .kill_en_i     (pipe_wr),
        .kill_rd_i     (RdW),
        .head_rd_o     (head_rd),
        .head_data_o   (head_data),
        .head_killed_o (head_killed),
        .full_o        (full),
        .empty_o       (empty),
        .count_o       (count)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alive_q   <= 1'b0;
            instret_q <= '0;
            err_q     <= 1'b0;
        end else begin
            alive_q <= 1'b1;
            if (ValidW) instret_q <= instret_q + 1'b1;
            if (ValidW && (ResultSrcW == RES_RSV)) err_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_arbiter_stage.sv
module tb_wb_arbiter_stage;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 64;

  logic              clk;
  logic              rst;
  logic              ValidW, RegWriteW;
  logic [REG_AW-1:0] RdW;
  logic [1:0]        ResultSrcW;
  logic [XLEN-1:0]   ALU_ResultW, ReadDataW, PCPlus4W;
  logic              div_valid;
  logic [REG_AW-1:0] div_rd;
  logic [XLEN-1:0]   div_data;
  logic              div_ready;
  logic [XLEN-1:0]   ResultW;
  logic              rf_we;
  logic [REG_AW-1:0] rf_addr;
  logic [XLEN-1:0]   rf_wdata;
  logic              wb_pending;
  logic [CNT_W-1:0]  instret;
  logic              err_src;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
    bit                killed;
  } ent_t;

  ent_t             mq[$];
  logic [CNT_W-1:0] m_instret;
  bit               m_err;
  bit               m_alive;
  bit               last_push;

  wb_arbiter_stage #(
    .XLEN(XLEN), .REG_AW(REG_AW), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst),
    .ValidW(ValidW), .RegWriteW(RegWriteW), .RdW(RdW), .ResultSrcW(ResultSrcW),
    .ALU_ResultW(ALU_ResultW), .ReadDataW(ReadDataW), .PCPlus4W(PCPlus4W),
    .div_valid(div_valid), .div_rd(div_rd), .div_data(div_data),
    .div_ready(div_ready), .ResultW(ResultW),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .wb_pending(wb_pending), .instret(instret), .err_src(err_src)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_w(input bit v, input bit w, input int rd, input int src,
                         input logic [XLEN-1:0] alu, input logic [XLEN-1:0] mem,
                         input logic [XLEN-1:0] pc4);
    ValidW      = v;
    RegWriteW   = w;
    RdW         = REG_AW'(rd);
    ResultSrcW  = 2'(src);
    ALU_ResultW = alu;
    ReadDataW   = mem;
    PCPlus4W    = pc4;
  endtask

  task automatic drive_div(input bit v, input int rd, input logic [XLEN-1:0] data);
    div_valid = v;
    div_rd    = REG_AW'(rd);
    div_data  = data;
  endtask

  task automatic idle_w();
    drive_w(0, 0, 0, 0, '0, '0, '0);
  endtask

  task automatic model_reset();
    mq.delete();
    m_instret = '0;
    m_err     = 0;
    m_alive   = 0;
  endtask

  // One clock cycle. Outputs are checked against the model at the falling
  // edge, and the model advances at the rising edge.
  task automatic cycle();
    logic [XLEN-1:0] er;
    bit pw, ew, er_ready, pop, push;
    ent_t e;
    @(negedge clk);
    case (ResultSrcW)
      2'd0: er = ALU_ResultW;
      2'd1: er = ReadDataW;
      2'd2: er = PCPlus4W;
      default: er = '0;
    endcase
    pw = ValidW && RegWriteW && (RdW != 0);
    ew = pw || (mq.size() > 0 && !mq[0].killed);
    er_ready = m_alive && (mq.size() < DEPTH);
    chk("ResultW", 64'(ResultW), 64'(er));
    chk("rf_we", 64'(rf_we), 64'(ew));
    if (ew) begin
      chk("rf_addr", 64'(rf_addr), pw ? 64'(RdW) : 64'(mq[0].rd));
      chk("rf_wdata", 64'(rf_wdata), pw ? 64'(er) : 64'(mq[0].data));
    end
    chk("div_ready", 64'(div_ready), 64'(er_ready));
    chk("wb_pending", 64'(wb_pending), 64'(mq.size() != 0));
    chk("instret", 64'(instret), 64'(m_instret));
    chk("err_src", 64'(err_src), 64'(m_err));
    pop  = (mq.size() > 0) && (mq[0].killed || !pw);
    push = div_valid && er_ready;
    last_push = push;
    @(posedge clk);
    if (pop) void'(mq.pop_front());
    if (pw) begin
      foreach (mq[i]) if (mq[i].rd == RdW) mq[i].killed = 1;
    end
    if (push) begin
      e.rd = div_rd;
      e.data = div_data;
      e.killed = (div_rd == 0) || (pw && div_rd == RdW);
      mq.push_back(e);
    end
    if (ValidW) m_instret = m_instret + 1;
    if (ValidW && ResultSrcW == 2'b11) m_err = 1;
    m_alive = 1;
    #1;
  endtask

  initial begin
    int k;
    // reset
    rst = 1'b0;
    idle_w();
    drive_div(0, 0, '0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", 64'(rf_we), 64'(0));
    chk("rst_div_ready", 64'(div_ready), 64'(0));
    chk("rst_wb_pending", 64'(wb_pending), 64'(0));
    chk("rst_instret", 64'(instret), 64'(0));
    chk("rst_err_src", 64'(err_src), 64'(0));
    rst = 1'b1;

    // Pipeline write to x5.
    drive_w(1, 1, 5, 0, 32'h18, 32'hdead, 32'hbeef);
    cycle();
    idle_w();
    cycle();
    chk("instret_after_one", 64'(instret), 64'(1));

    // A single divider result drains into an idle W slot.
    drive_div(1, 7, 32'h6);
    cycle();
    drive_div(0, 0, '0);
    cycle();
    cycle();

    // The buffer fills under pipeline pressure, then drains in FIFO order.
    k = 0;
    for (int c = 0; c < 6; c++) begin
      drive_w(1, 1, 1 + c, 0, 32'h100 + 32'(c), '0, '0);
      drive_div(k < 5, 10 + k, 32'h200 + 32'(k));
      cycle();
      if (last_push) k++;
    end
    idle_w();
    for (int c = 0; c < 12; c++) begin
      drive_div(k < 5, 10 + k, 32'h200 + 32'(k));
      cycle();
      if (last_push) k++;
    end
    drive_div(0, 0, '0);
    chk("all_five_pushed", 64'(k), 64'(5));

    // WAW kill: a buffered x9 result is superseded by a pipeline write to x9.
    drive_div(1, 9, 32'h99);
    cycle();
    drive_div(0, 0, '0);
    drive_w(1, 1, 9, 0, 32'h4, '0, '0);
    cycle();
    idle_w();
    cycle();
    cycle();

    // A divider result and a pipeline write to the same register arrive together.
    drive_w(1, 1, 3, 1, '0, 32'h77, '0);
    drive_div(1, 3, 32'h55);
    cycle();
    idle_w();
    drive_div(1, 0, 32'h66);
    cycle();
    drive_div(0, 0, '0);
    cycle();
    cycle();

    // Reserved result select.
    drive_w(1, 1, 4, 3, 32'h1, 32'h2, 32'h3);
    cycle();
    idle_w();
    cycle();
    cycle();

    // Reset asserted while three entries are buffered.
    for (int c = 0; c < 3; c++) begin
      drive_w(1, 1, 1, 0, 32'h300 + 32'(c), '0, '0);
      drive_div(1, 11 + c, 32'h400 + 32'(c));
      cycle();
    end
    drive_div(0, 0, '0);
    chk("pre_reset_pending", 64'(wb_pending), 64'(1));
    rst = 1'b0;
    #1;
    chk("mid_rst_rf_we", 64'(rf_we), 64'(0));
    chk("mid_rst_div_ready", 64'(div_ready), 64'(0));
    model_reset();
    idle_w();
    @(posedge clk);
    #1;
    chk("post_rst_pending", 64'(wb_pending), 64'(0));
    chk("post_rst_instret", 64'(instret), 64'(0));
    chk("post_rst_err", 64'(err_src), 64'(0));
    rst = 1'b1;
    cycle();

    // random traffic
    for (int c = 0; c < 400; c++) begin
      drive_w($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 3),
              ($urandom_range(0, 19) == 0) ? 3 : $urandom_range(0, 2),
              $urandom, $urandom, $urandom);
      drive_div($urandom_range(0, 2) != 0, $urandom_range(0, 3), $urandom);
      cycle();
    end
    idle_w();
    drive_div(0, 0, '0);
    repeat (DEPTH + 2) cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_arbiter_stage.md
Name: wb_arbiter_stage

Overview:
- Parametrised writeback stage for the RV32IM 5-stage pipeline.
- Selects the in-order W-stage result (ALU / load data / PC+4).
- Merges late results from the multi-cycle M-extension divider through a small buffer onto the single register-file write port.
- Keeps a retired-instruction counter and a sticky error flag for illegal result-select encodings.

Parameters:
XLEN, 32, datapath width
REG_AW, 5, register address width
DEPTH, 4, late-result buffer entries (power of 2, >=2)
CNT_W, 64, retired-instruction counter width

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
ValidW  in  1  W-stage slot holds a real instruction
RegWriteW  in  1  W-stage instruction writes rd
RdW  in  REG_AW  W-stage destination register
ResultSrcW  in  2  result select
ALU_ResultW, ReadDataW, PCPlus4W  in  XLEN each  candidate results
div_valid  in  1  divider result offered
div_rd  in  REG_AW  divider destination
div_data  in  XLEN  divider result
div_ready  out  1  buffer can accept
ResultW  out  XLEN  selected W-stage result (forwarding path)
rf_we  out  1  register-file write enable
rf_addr  out  REG_AW  register-file write address
rf_wdata  out  XLEN  register-file write data
wb_pending  out  1  buffer non-empty
instret  out  CNT_W  retired-instruction count
err_src  out  1  sticky: ResultSrcW==2'b11 seen on a valid slot

Behaviour:
- Reset (rst low, async):
  - buffer emptied, instret=0, err_src=0.
  - rf_we=0, div_ready=0 while rst is low.
  - div_ready=1 from the first edge after release.
- ResultW (combinational, 0 latency): 00 ALU_ResultW, 01 ReadDataW, 10 PCPlus4W, 11 zero.
- pipe_wr = ValidW & RegWriteW & (RdW!=0).
- Write-port arbitration (combinational, same cycle):
  - pipe_wr: rf_we=1, rf_addr=RdW, rf_wdata=ResultW. The pipeline always wins and is never stalled.
  - else if buffer head is valid and not killed: rf_we=1, rf_addr/rf_wdata from head; head pops at the edge.
  - else if head is killed: head pops at the edge, rf_we=0.
  - else rf_we=0.
  - A killed head pops even when pipe_wr=1.
- Accept: push on div_valid & div_ready.
  - div_ready = !full. A full buffer does not accept a push in the same cycle even if it pops.
  - A pushed entry is visible at the head from the next cycle at the earliest (no bypass).
  - div_rd==0 is accepted and pushed pre-killed.
- WAW kill:
  - Every cycle with pipe_wr, all buffered entries whose rd==RdW are marked killed at the edge.
  - An entry pushed in the same cycle with div_rd==RdW is pushed killed, because the divider result is the older value.
  - A killed entry never writes.
- Simultaneous push and pop (not full): both happen at the edge; count is unchanged. Read/write pointers wrap modulo DEPTH.
- wb_pending = count!=0.
- instret increments by 1 on every edge with ValidW=1, regardless of RegWriteW. It wraps modulo 2^CNT_W.
- Divider results are counted at issue, not here.
- err_src is set on any edge with ValidW & ResultSrcW==2'b11 and is cleared only by reset.
- Reset mid-operation discards buffered entries, including unwritten results.
- Scoreboarding of RAW hazards on pending divider rd is the issue stage's responsibility.

Decomposition:
- Package wb_pkg: result-select constants RES_ALU=2'b00, RES_MEM=2'b01, RES_PC4=2'b10, RES_RSV=2'b11; default XLEN/REG_AW.
- Sub-module wb_late_fifo: DEPTH-entry synchronous FIFO of {rd, data, killed}.
  - Parallel rd-compare kill port.
  - Pre-killed push input.
  - full/empty/count outputs.
- The top level holds the mux, arbitration, instret and err_src.

Test Plan:
- Reset, then ValidW=1, RegWriteW=1, RdW=5, ResultSrcW=00, ALU_ResultW=0x18 -> ResultW=0x18, rf_we=1, rf_addr=5, rf_wdata=0x18 same cycle; instret=1 after the edge.
- Divider push rd=7 data=0x6 while the W slot is idle -> next cycle rf_we=1, rf_addr=7, rf_wdata=0x6; wb_pending=0 after that edge.
- Back-to-back pipeline writes for 6 cycles while pushing 5 divider results -> div_ready drops after 4 pushes; the 5th is held until a slot frees; entries drain in FIFO order once pipe_wr=0.
- Buffered divider entry rd=9, then pipeline write rd=9 data 0x4 -> reg 9 receives only 0x4; the killed entry pops with rf_we=0.
- ResultSrcW=11 with ValidW=1 -> ResultW=0, err_src=1 and held.
- Assert rst low with 3 entries buffered -> rf_we=0 and div_ready=0 immediately; after release wb_pending=0 and instret=0.
